// File: rtl/regfile_writeback.sv
// Write-back register file: 32x32 array behind a one-entry commit buffer,
// with same-cycle bypass and a post-reset clear sequencer.
module regfile_writeback #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] WD,
    input  logic          WZ,
    input  logic          W_valid,
    output logic          W_ready,
    output logic          Zflag,
    output logic          busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] CNT_ONE = AW'(1);
    localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          pend_v_q;
    logic [AW-1:0] pend_a_q;
    logic [DW-1:0] pend_d_q;
    logic          zflag_q;

    logic [DW-1:0] mem_q [DEPTH];

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    assign W_ready = (state_q == RUN);
    assign busy    = (state_q == CLEAR);
    assign Zflag   = zflag_q;
    assign accept  = W_valid && W_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            pend_v_q <= 1'b0;
            zflag_q  <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_MAX) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        zflag_q <= WZ;
                    end
                end
                default: state_q <= CLEAR;
            endcase
            pend_v_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            pend_a_q <= WA;
            pend_d_q <= WD;
        end
    end

    // Clear and commit never overlap: nothing is pending while clearing.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
            end else if (pend_v_q && (pend_a_q != '0)) begin
                mem_we = 1'b1;
                mem_wa = pend_a_q;
                mem_wd = pend_d_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = '0;
        if (state_q == RUN && a != '0) begin
            if (pend_v_q && pend_a_q == a) begin
                r = pend_d_q;
            end else begin
                r = mem_q[a];
            end
        end
        return r;
    endfunction

    assign RD1 = rd(RA1);
    assign RD2 = rd(RA2);

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed checks of regfile_writeback against a
// queue/array reference model of the write-back rules.
module tb_regfile_writeback;

    logic        clk;
    logic        reset;
    logic [4:0]  RA1, RA2, WA;
    logic [31:0] RD1, RD2, WD;
    logic        WZ, W_valid;
    logic        W_ready, Zflag, busy;

    int errors = 0;
    int checks = 0;

    regfile_writeback #(.DW(32), .AW(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .RA1    (RA1),
        .RA2    (RA2),
        .RD1    (RD1),
        .RD2    (RD2),
        .WA     (WA),
        .WD     (WD),
        .WZ     (WZ),
        .W_valid(W_valid),
        .W_ready(W_ready),
        .Zflag  (Zflag),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] m_arr [32];
    wr_t         m_pend [$];
    int          m_clear_left = 32;
    logic        m_z = 1'b0;

    function automatic logic [31:0] m_rd(input int a);
        if (m_clear_left > 0 || a == 0) return 32'h0;
        foreach (m_pend[i]) if (m_pend[i].a == a) return m_pend[i].d;
        return m_arr[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        wr_t w;
        if (reset) begin
            m_clear_left = 32;
            m_pend.delete();
            m_z = 1'b0;
            for (int i = 0; i < 32; i++) m_arr[i] = 32'h0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else begin
            if (m_pend.size() > 0) begin
                w = m_pend.pop_front();
                if (w.a != 0) m_arr[w.a] = w.d;
            end
            if (W_valid) begin
                w.a = int'(WA);
                w.d = WD;
                m_pend.push_back(w);
                m_z = WZ;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] wa,
                        input logic [31:0] wd, input logic wz,
                        input logic [4:0] ra1, input logic [4:0] ra2);
        reset = r; W_valid = v; WA = wa; WD = wd; WZ = wz;
        RA1 = ra1; RA2 = ra2;
        @(posedge clk);
        model_edge();
        #1;
        chk("W_ready", {31'h0, W_ready}, {31'h0, m_clear_left == 0});
        chk("busy", {31'h0, busy}, {31'h0, m_clear_left > 0});
        chk("Zflag", {31'h0, Zflag}, {31'h0, m_z});
        chk("RD1", RD1, m_rd(int'(RA1)));
        chk("RD2", RD2, m_rd(int'(RA2)));
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, ra1, ra2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_arr[i] = 32'h0;
        reset = 1'b1; W_valid = 1'b0; WA = '0; WD = '0; WZ = 1'b0;
        RA1 = '0; RA2 = '0;

        // Reset then clear with W_valid held high.
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_ready", {31'h0, W_ready}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1,
                 5'($urandom), 5'($urandom));
            if (i < 31) chk("clr_busy", {31'h0, busy}, 32'h1);
        end
        chk("clr_done_ready", {31'h0, W_ready}, 32'h1);
        chk("clr_done_z", {31'h0, Zflag}, 32'h0);

        // r5 = DEADBEEF: bypass then array.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        chk("r5_bypass", RD1, 32'hDEADBEEF);
        idle(5'd5, 5'd0);
        chk("r5_array", RD1, 32'hDEADBEEF);
        chk("r5_z", {31'h0, Zflag}, 32'h0);

        // Write to R0 never lands, Z still updates.
        step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0);
        chk("r0_bypass", RD1, 32'h0);
        chk("r0_z", {31'h0, Zflag}, 32'h1);
        idle(5'd0, 5'd5);
        idle(5'd0, 5'd0);
        chk("r0_array", RD1, 32'h0);

        // Back-to-back writes, same register then another.
        step(1'b0, 1'b1, 5'd7, 32'd1, 1'b0, 5'd7, 5'd8);
        chk("b2b_1", RD1, 32'd1);
        step(1'b0, 1'b1, 5'd7, 32'd2, 1'b0, 5'd7, 5'd8);
        chk("b2b_2", RD1, 32'd2);
        step(1'b0, 1'b1, 5'd8, 32'd3, 1'b0, 5'd7, 5'd8);
        chk("b2b_3a", RD1, 32'd2);
        chk("b2b_3b", RD2, 32'd3);
        idle(5'd7, 5'd8);
        idle(5'd7, 5'd8);
        chk("b2b_idle_r7", RD1, 32'd2);
        chk("b2b_idle_r8", RD2, 32'd3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 5'($urandom), $urandom, 1'($urandom),
                 5'($urandom), 5'($urandom));
        end
        while (m_clear_left > 0) idle(5'($urandom), 5'($urandom));

        // Pending r9 discarded by reset; reset held several cycles.
        step(1'b0, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd9, 5'd9);
        chk("r9_bypass", RD1, 32'hAA);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
            chk("r9_clear", RD1, 32'h0);
        end
        chk("r9_run_ready", {31'h0, W_ready}, 32'h1);
        for (int a = 0; a < 32; a++) begin
            idle(5'(a), 5'(31 - a));
            chk("sweep_rd1", RD1, 32'h0);
            chk("sweep_rd2", RD2, 32'h0);
        end

        // Top address.
        step(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd31);
        chk("r31_bypass", RD2, 32'hFFFFFFFF);
        idle(5'd30, 5'd31);
        idle(5'd30, 5'd31);
        chk("r31_array", RD2, 32'hFFFFFFFF);
        chk("r30_zero", RD1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
